// File: rtl/stddev_pkg.sv
// Shared state encoding and width helpers for the streaming mean/stddev block.
package stddev_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_CALC  = 2'd1,
        ST_SQRT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Worst case is N samples of all-ones, so log2(N) guard bits suffice.
    function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned log2_n);
        return data_w + log2_n;
    endfunction

    function automatic int unsigned sumsq_width(input int unsigned data_w, input int unsigned log2_n);
        return 2 * data_w + log2_n;
    endfunction

    function automatic int unsigned sqrt_in_width(input int unsigned data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/stream_stddev_isqrt.sv
// Sequential restoring integer square root: one root bit per cycle, DATA_W cycles per result.
module isqrt_seq
    import stddev_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               clear_i,
    input  logic                               start_i,
    input  logic [sqrt_in_width(DATA_W)-1:0]   radicand_i,
    output logic [DATA_W-1:0]                  root_o,
    output logic                               done_o
);

    localparam int unsigned IN_W  = sqrt_in_width(DATA_W);
    localparam int unsigned REM_W = DATA_W + 2;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]     rad_q, rad_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   root_q, root_d;

    logic [REM_W+1:0]    rem_t;
    logic [REM_W+1:0]    trial;
    logic [REM_W+1:0]    rem_sub;
    logic                fits;

    always_comb begin
        rem_t   = {rem_q, rad_q[IN_W-1 -: 2]};
        trial   = {2'b00, root_q, 2'b01};
        fits    = (rem_t >= trial);
        rem_sub = rem_t - trial;

        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;

        if (clear_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
            rad_d  = '0;
            rem_d  = '0;
            root_d = '0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(DATA_W);
            rad_d  = radicand_i;
            rem_d  = '0;
            root_d = '0;
        end else if (busy_q) begin
            // Remainder stays below 2*root+1, so dropping the top two bits is lossless.
            rad_d  = rad_q << 2;
            rem_d  = fits ? REM_W'(rem_sub) : REM_W'(rem_t);
            root_d = {root_q[DATA_W-2:0], fits};
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
        end
    end

    assign root_o = root_q;
    assign done_o = done_q;

endmodule

// File: rtl/stream_stddev.sv
// Windowed mean and standard deviation over 2**LOG2_N unsigned samples.
// Define STDDEV_VARIANCE_OUT_EN to expose the window variance on var_out.
module stream_stddev
    import stddev_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2_N = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_W-1:0]     mean_out,
    output logic [DATA_W-1:0]     sd_out,
`ifdef STDDEV_VARIANCE_OUT_EN
    output logic [2*DATA_W-1:0]   var_out,
`endif
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned SUM_W = sum_width(DATA_W, LOG2_N);
    localparam int unsigned SQ_W  = sumsq_width(DATA_W, LOG2_N);
    localparam int unsigned VAR_W = sqrt_in_width(DATA_W);

    state_e               state_q, state_d;
    logic [LOG2_N-1:0]    cnt_q, cnt_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [SQ_W-1:0]      sumsq_q, sumsq_d;
    logic [DATA_W-1:0]    mean_calc_q, mean_calc_d;
    logic [DATA_W-1:0]    mean_q, mean_d;
    logic [DATA_W-1:0]    sd_q, sd_d;
    logic                 ready_en_q;

    logic [DATA_W-1:0]    mean_c;
    logic [VAR_W-1:0]     ex2_c;
    logic [VAR_W-1:0]     msq_c;
    logic [VAR_W-1:0]     var_c;
    logic                 sqrt_start;
    logic                 sqrt_done;
    logic [DATA_W-1:0]    sqrt_root;

    always_comb begin
        mean_c = DATA_W'(sum_q >> LOG2_N);
        ex2_c  = VAR_W'(sumsq_q >> LOG2_N);
        msq_c  = VAR_W'(mean_c) * VAR_W'(mean_c);
        var_c  = (ex2_c >= msq_c) ? (ex2_c - msq_c) : '0;

        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sumsq_d     = sumsq_q;
        mean_calc_d = mean_calc_q;
        mean_d      = mean_q;
        sd_d        = sd_q;
        sqrt_start  = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        unique case (state_q)
            ST_ACCUM: begin
                in_ready = ready_en_q;
                if (in_valid && ready_en_q) begin
                    sum_d   = sum_q + SUM_W'(in_data);
                    sumsq_d = sumsq_q + SQ_W'(in_data) * SQ_W'(in_data);
                    cnt_d   = cnt_q + LOG2_N'(1);
                    if (cnt_q == '1) begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                mean_calc_d = mean_c;
                sqrt_start  = 1'b1;
                state_d     = ST_SQRT;
            end
            ST_SQRT: begin
                // Publish mean and sd together so the outputs never mix two windows.
                if (sqrt_done) begin
                    mean_d  = mean_calc_q;
                    sd_d    = sqrt_root;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    sum_d   = '0;
                    sumsq_d = '0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        if (flush) begin
            state_d     = ST_ACCUM;
            cnt_d       = '0;
            sum_d       = '0;
            sumsq_d     = '0;
            mean_calc_d = mean_calc_q;
            mean_d      = mean_q;
            sd_d        = sd_q;
            sqrt_start  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            sum_q       <= '0;
            sumsq_q     <= '0;
            mean_calc_q <= '0;
            mean_q      <= '0;
            sd_q        <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sumsq_q     <= sumsq_d;
            mean_calc_q <= mean_calc_d;
            mean_q      <= mean_d;
            sd_q        <= sd_d;
            ready_en_q  <= 1'b1;
        end
    end

    isqrt_seq #(
        .DATA_W (DATA_W)
    ) u_isqrt (
        .clk        (clk),
        .rstn       (rstn),
        .clear_i    (flush),
        .start_i    (sqrt_start),
        .radicand_i (var_c),
        .root_o     (sqrt_root),
        .done_o     (sqrt_done)
    );

`ifdef STDDEV_VARIANCE_OUT_EN
    logic [VAR_W-1:0] var_calc_q;
    logic [VAR_W-1:0] var_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            var_calc_q <= '0;
            var_q      <= '0;
        end else if (!flush) begin
            if (state_q == ST_CALC) begin
                var_calc_q <= var_c;
            end
            if (state_q == ST_SQRT && sqrt_done) begin
                var_q <= var_calc_q;
            end
        end
    end

    assign var_out = var_q;
`endif

    assign mean_out = mean_q;
    assign sd_out   = sd_q;

endmodule

// File: tb/tb_stream_stddev.sv
// Directed scoreboard bench for stream_stddev: three instances (LOG2_N = 2, 1, 12) on one clock.
module tb_stream_stddev;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [2:0][DW-1:0]   in_data;
    logic [2:0]           in_valid;
    logic [2:0]           in_ready;
    logic [2:0]           flush;
    logic [2:0][DW-1:0]   mean_out;
    logic [2:0][DW-1:0]   sd_out;
    logic [2:0]           out_valid;
    logic [2:0]           out_ready;
`ifdef STDDEV_VARIANCE_OUT_EN
    logic [2:0][2*DW-1:0] var_out;
`endif

    always #5 clk = ~clk;

    stream_stddev #(.DATA_W(DW), .LOG2_N(2)) u_l2 (
        .clk(clk), .rstn(rstn), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .flush(flush[0]), .mean_out(mean_out[0]), .sd_out(sd_out[0]),
`ifdef STDDEV_VARIANCE_OUT_EN
        .var_out(var_out[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    stream_stddev #(.DATA_W(DW), .LOG2_N(1)) u_l1 (
        .clk(clk), .rstn(rstn), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .flush(flush[1]), .mean_out(mean_out[1]), .sd_out(sd_out[1]),
`ifdef STDDEV_VARIANCE_OUT_EN
        .var_out(var_out[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    stream_stddev #(.DATA_W(DW), .LOG2_N(12)) u_l12 (
        .clk(clk), .rstn(rstn), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .flush(flush[2]), .mean_out(mean_out[2]), .sd_out(sd_out[2]),
`ifdef STDDEV_VARIANCE_OUT_EN
        .var_out(var_out[2]),
`endif
        .out_valid(out_valid[2]), .out_ready(out_ready[2])
    );

    typedef struct {
        longint mean;
        longint sd;
        longint vr;
        int     acc;
    } exp_t;

    exp_t   sb[$];
    longint m_sum;
    longint m_sq;
    int     m_cnt;
    int     cyc = 0;
    int     n_assert = 0;
    int     n_fail = 0;

    function automatic int lg(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 12;
        endcase
    endfunction

    function automatic longint isqrt_ref(input longint v);
        longint r;
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_clr();
        m_sum = 0;
        m_sq  = 0;
        m_cnt = 0;
    endtask

    task automatic send(input int d, input longint x, input bit expect_res);
        int     k;
        exp_t   e;
        longint ex2;
        k = 0;
        in_data[d]  = DW'(x);
        in_valid[d] = 1'b1;
        while (!in_ready[d] && k < 50) begin
            step();
            k++;
        end
        if (!in_ready[d]) chk("in_ready_wait", in_ready[d], 1);
        step();
        in_valid[d] = 1'b0;
        m_sum += x;
        m_sq  += x * x;
        m_cnt++;
        if (m_cnt == (1 << lg(d))) begin
            if (expect_res) begin
                e.mean = m_sum >> lg(d);
                ex2    = m_sq >> lg(d);
                e.vr   = ex2 - e.mean * e.mean;
                if (e.vr < 0) e.vr = 0;
                e.sd   = isqrt_ref(e.vr);
                e.acc  = cyc;
                sb.push_back(e);
            end
            model_clr();
        end
    endtask

    task automatic collect(input int d, input int hold);
        int   k;
        exp_t e;
        k = 0;
        while (!out_valid[d] && k < 200) begin
            step();
            k++;
        end
        chk("out_valid_rise", out_valid[d], 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("mean_out", mean_out[d], e.mean);
        chk("sd_out", sd_out[d], e.sd);
`ifdef STDDEV_VARIANCE_OUT_EN
        chk("var_out", var_out[d], e.vr);
`endif
        chk("latency", cyc - e.acc, DW + 2);
        chk("in_ready_hold", in_ready[d], 0);
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 16'd1234;
            step();
            chk("hold_valid", out_valid[d], 1);
            chk("hold_mean", mean_out[d], e.mean);
            chk("hold_sd", sd_out[d], e.sd);
            chk("hold_in_ready", in_ready[d], 0);
        end
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        chk("handshake_valid_low", out_valid[d], 0);
        chk("handshake_in_ready", in_ready[d], 1);
        chk("retain_mean", mean_out[d], e.mean);
        chk("retain_sd", sd_out[d], e.sd);
    endtask

    task automatic do_flush(input int d, input bit with_sample);
        flush[d] = 1'b1;
        if (with_sample) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 16'd999;
        end
        step();
        flush[d]    = 1'b0;
        in_valid[d] = 1'b0;
        model_clr();
        chk("flush_out_valid", out_valid[d], 0);
        chk("flush_in_ready", in_ready[d], 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        in_data   = '0;
        in_valid  = '0;
        flush     = '0;
        out_ready = '0;
        model_clr();

        // Reset state
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", in_ready[d], 0);
            chk("rst_out_valid", out_valid[d], 0);
            chk("rst_mean", mean_out[d], 0);
            chk("rst_sd", sd_out[d], 0);
        end
        #2 rstn = 1'b1;
        chk("in_ready_before_edge", in_ready[0], 0);
        step();
        for (int d = 0; d < 3; d++) chk("in_ready_after_release", in_ready[d], 1);

        // Constant window, then alternating 0/2
        for (int i = 0; i < 4; i++) send(0, 100, 1);
        collect(0, 0);
        send(0, 0, 1); send(0, 2, 1); send(0, 0, 1); send(0, 2, 1);
        collect(0, 0);

        // Long hold with a competing sample; next window must not include it
        send(0, 10, 1); send(0, 20, 1); send(0, 30, 1); send(0, 40, 1);
        collect(0, 10);
        for (int i = 0; i < 4; i++) send(0, 5, 1);
        collect(0, 0);

        // Flush mid-window with a simultaneous sample
        send(0, 50, 1); send(0, 60, 1);
        do_flush(0, 1);
        for (int i = 0; i < 4; i++) send(0, 7, 1);
        collect(0, 0);

        // Flush during the square root: no result may appear
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 0);
        repeat (5) step();
        do_flush(0, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen |= out_valid[0];
        end
        chk("no_valid_after_sqrt_flush", seen, 0);
        chk("mean_kept_after_flush", mean_out[0], 7);

        // Asynchronous reset during the square root
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 0);
        repeat (6) step();
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_mean", mean_out[0], 0);
        chk("async_rst_sd", sd_out[0], 0);
        chk("async_rst_valid", out_valid[0], 0);
        chk("async_rst_in_ready", in_ready[0], 0);
        step();
        #2 rstn = 1'b1;
        step();
        chk("in_ready_after_rst", in_ready[0], 1);
        model_clr();
        send(0, 9, 1); send(0, 9, 1); send(0, 9, 1); send(0, 13, 1);
        collect(0, 0);

        // Extremes: two-sample window and a full 4096-sample all-ones window
        send(1, 0, 1); send(1, 65535, 1);
        collect(1, 0);
        for (int i = 0; i < 4096; i++) send(2, 65535, 1);
        collect(2, 0);

        // Random windows
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 4; i++) send(0, longint'($urandom_range(0, 65535)), 1);
            collect(0, 0);
        end
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 2; i++) send(1, longint'($urandom_range(0, 65535)), 1);
            collect(1, 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
